microgreen_uart_tx: RTL and testbench

UART 8N1 transmitter: the transmit end of the board's 9600-baud override/telemetry link. Accepts raw bytes over a valid/ready handshake. Also auto-formats a 3-byte classification report ("H"/"W", hex hidden-activation nibble, LF) when the BNN signals a new result. Bytes pass through a small FIFO into a bit-serial shifter driving a uio output pin.

---
 rtl/microgreen_uart_pkg.sv | 29 ++
 rtl/microgreen_uart_tx_if.sv | 23 ++
 rtl/microgreen_byte_fifo.sv | 73 +++++++
 rtl/microgreen_uart_tx.sv | 196 +++++++++++++++++++
 tb/tb_microgreen_uart_tx.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/microgreen_uart_pkg.sv
// Shared constants for the microgreen UART transmitter: report ASCII codes,
// default baud divisor and the TX FSM state encoding.
// Also provides the nibble-to-ASCII-hex helper used by the report formatter.
package microgreen_uart_pkg;

  localparam logic [7:0] CH_H  = 8'h48;
  localparam logic [7:0] CH_W  = 8'h57;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_A  = 8'h41;

  // 25 MHz / 9600 baud
  localparam int BAUD_DIV_DEFAULT = 2604;

  // ST_PARITY is only reachable when parity generation is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return CH_0 + {4'd0, nib};
    else             return CH_A + {4'd0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/microgreen_uart_tx_if.sv
// Host-side handshake bundle of the UART transmitter: raw-byte valid/ready
// channel plus the BNN report trigger and payload.
// master = producer (BNN / host), slave = transmitter.
interface microgreen_uart_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       report_trig;
  logic       report_pred;
  logic [3:0] report_hidden;

  modport master (
    output tx_data, tx_valid, report_trig, report_pred, report_hidden,
    input  tx_ready
  );

  modport slave (
    input  tx_data, tx_valid, report_trig, report_pred, report_hidden,
    output tx_ready
  );

endinterface

// File: rtl/microgreen_byte_fifo.sv
// Purpose: synchronous byte FIFO with a 1-or-3-byte push and a 1-byte pop.
// Latency: pushed data visible on pop_dat_o the edge after the push.
// Backpressure: none internally; the caller must only push when free_o >= count.
// Ports: clk, rst_n; push_i/push_cnt_i/push_dat_i (byte 0 in [7:0] goes first);
//        pop_i/pop_dat_o (head byte, combinational); level_o, free_o occupancy.
module microgreen_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [1:0]               push_cnt_i,
  input  logic [23:0]              push_dat_i,
  input  logic                     pop_i,
  output logic [7:0]               pop_dat_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [$clog2(DEPTH):0]   free_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wa1, wa2;
  logic [LW-1:0] level_q, level_d;

  // Pointers are AW bits wide so the additions wrap modulo DEPTH for free.
  assign wa1 = wr_ptr_q + AW'(1);
  assign wa2 = wr_ptr_q + AW'(2);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + AW'(push_cnt_i);
      level_d  = level_d + LW'(push_cnt_i);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      level_d  = level_d - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; level_q guards every read.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_dat_i[7:0];
      if (push_cnt_i == 2'd3) begin
        mem_q[wa1] <= push_dat_i[15:8];
        mem_q[wa2] <= push_dat_i[23:16];
      end
    end
  end

  assign pop_dat_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;
  assign free_o    = LW'(DEPTH) - level_q;

endmodule

// File: rtl/microgreen_uart_tx.sv
// Purpose: UART 8N1 transmitter with raw-byte input and auto-formatted BNN report ("H"/"W", hex, LF).
// Latency: byte written at edge k into an idle, empty block drives the start bit from edge k+1.
// Backpressure: tx_ready drops when the FIFO is full, ena is low or a report is being enqueued.
// Ports: clk, rst_n, ena; host_if (raw byte valid/ready + report trigger/payload);
//        uart_tx serial line (idle high), busy, fifo_level, sticky overflow (report dropped).
// Build option: define UART_PARITY_EN to insert an even-parity bit before the stop bit.
module microgreen_uart_tx
  import microgreen_uart_pkg::*;
#(
  parameter int BAUD_DIV   = BAUD_DIV_DEFAULT,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  microgreen_uart_tx_if.slave           host_if,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  // ---------------- report formatter and push arbitration ----------------
  logic [LW-1:0] level, free;
  logic [7:0]    fifo_dat;
  logic          fifo_empty, pop;
  logic          rpt_take, rpt_drop, raw_take, push;
  logic [1:0]    push_cnt;
  logic [23:0]   push_dat;
  logic [7:0]    rpt_b0;
  logic          overflow_q;

  // Space is judged on the pre-pop level: a same-cycle pop never makes room.
  assign rpt_take = ena & host_if.report_trig & (free >= LW'(3));
  assign rpt_drop = ena & host_if.report_trig & (free <  LW'(3));
  assign host_if.tx_ready = ena & (free != '0) & ~host_if.report_trig;
  assign raw_take = host_if.tx_valid & host_if.tx_ready;

  assign rpt_b0   = host_if.report_pred ? CH_H : CH_W;
  assign push     = rpt_take | raw_take;
  assign push_cnt = rpt_take ? 2'd3 : 2'd1;
  assign push_dat = rpt_take ? {CH_LF, hex_ascii(host_if.report_hidden), rpt_b0}
                             : {16'h0000, host_if.tx_data};

  microgreen_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_cnt_i (push_cnt),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .pop_dat_o  (fifo_dat),
    .level_o    (level),
    .free_o     (free)
  );

  assign fifo_empty = (level == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        overflow_q <= 1'b0;
    else if (rpt_drop) overflow_q <= 1'b1;
  end

  // ---------------- TX FSM ----------------
  tx_state_e     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          baud_tc;
`ifdef UART_PARITY_EN
  logic          par_q, par_d;
`endif

  assign baud_tc = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
`ifdef UART_PARITY_EN
    par_d   = par_q;
`endif
    if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) pop = 1'b1;
        end
        ST_START: begin
          if (baud_tc) begin
            baud_d  = '0;
            bit_d   = 3'd0;
            state_d = ST_DATA;
          end else begin
            baud_d = baud_q + CW'(1);
          end
        end
        ST_DATA: begin
          if (baud_tc) begin
            baud_d = '0;
            if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              bit_d   = bit_q + 3'd1;
              shreg_d = {1'b0, shreg_q[7:1]};
            end
          end else begin
            baud_d = baud_q + CW'(1);
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (baud_tc) begin
            baud_d  = '0;
            state_d = ST_STOP;
          end else begin
            baud_d = baud_q + CW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (baud_tc) begin
            baud_d  = '0;
            state_d = ST_IDLE;
            // Chain straight into the next frame so there is no idle gap.
            if (!fifo_empty) pop = 1'b1;
          end else begin
            baud_d = baud_q + CW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Byte is captured at pop; later FIFO writes cannot touch the frame in flight.
      if (pop) begin
        shreg_d = fifo_dat;
        baud_d  = '0;
        state_d = ST_START;
`ifdef UART_PARITY_EN
        par_d   = ^fifo_dat;
`endif
      end
    end

    // Line level is registered from the next state to keep uart_tx glitch-free.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shreg_d[0];
`ifdef UART_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shreg_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end
`endif

  assign uart_tx    = tx_q;
  assign busy       = (state_q != ST_IDLE) | ~fifo_empty;
  assign fifo_level = level;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_microgreen_uart_tx.sv
// Self-checking bench for microgreen_uart_tx with BAUD_DIV=16, FIFO_DEPTH=8.
// Stimulus pushes expected bytes into a scoreboard; a serial receiver process
// decodes uart_tx (counting only enabled cycles) and compares each frame.
module tb_microgreen_uart_tx;

  localparam int BD = 16;
`ifdef UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME = FB * BD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       uart_tx, busy, overflow;
  logic [3:0] fifo_level;

  microgreen_uart_tx_if u_if();

  microgreen_uart_tx #(
    .BAUD_DIV   (BD),
    .FIFO_DEPTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .host_if    (u_if),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] sb[$];
  int starts[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    u_if.tx_valid = 1'b1;
    u_if.tx_data  = b;
    @(negedge clk);
    check("tx_ready_on_push", u_if.tx_ready, 1'b1);
    tick();
    u_if.tx_valid = 1'b0;
    sb.push_back(b);
  endtask

  task automatic wait_idle(input int bound, input int ref_cyc, output int elapsed);
    elapsed = -1;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (!busy) begin
        elapsed = cyc - ref_cyc;
        break;
      end
    end
  endtask

  // Serial receiver / scoreboard checker
  initial begin
    int n, bi;
    logic en, active;
    logic [7:0] sh, exp_b;
    active = 1'b0;
    n = 0;
    sh = 8'h00;
    forever begin
      @(posedge clk);
      en = ena;
      #1;
      if (!rst_n) begin
        active = 1'b0;
      end else if (!active) begin
        if (uart_tx == 1'b0) begin
          active = 1'b1;
          n = 0;
          starts.push_back(cyc);
        end
      end else if (en) begin
        n++;
        if (n % BD == BD / 2) begin
          bi = n / BD;
          if (bi == 0) check("start_bit", uart_tx, 1'b0);
          else if (bi <= 8) sh[bi-1] = uart_tx;
`ifdef UART_PARITY_EN
          else if (bi == 9) check("parity_bit", uart_tx, ^sh);
`endif
          else if (bi == FB - 1) begin
            check("stop_bit", uart_tx, 1'b1);
            check("frame_expected", (sb.size() != 0), 1'b1);
            if (sb.size() != 0) begin
              exp_b = sb.pop_front();
              check("rx_byte", sh, exp_b);
            end
            active = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int t, c1;
    logic v, changed;
    logic [7:0] fill [9];
    fill = '{8'h00, 8'hFF, 8'hA5, 8'h5A, 8'h01, 8'h80, 8'h3C, 8'h11, 8'hEE};

    rst_n = 1'b1;
    ena   = 1'b1;
    u_if.tx_valid      = 1'b0;
    u_if.tx_data       = 8'h00;
    u_if.report_trig   = 1'b0;
    u_if.report_pred   = 1'b0;
    u_if.report_hidden = 4'h0;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_level", fifo_level, 4'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_tx_ready", u_if.tx_ready, 1'b1);

    // Single raw byte 0x41
    push(8'h41);
    check("t1_level_after_push", fifo_level, 4'd1);
    tick();
    c1 = cyc;
    check("t1_start_low_next_edge", uart_tx, 1'b0);
    check("t1_level_after_pop", fifo_level, 4'd0);
    wait_idle(400, c1, t);
    check("t1_frame_cycles", t, FRAME);
    check("t1_line_idle", uart_tx, 1'b1);

    // Report H, hidden 0xB -> 'H' 'B' LF back-to-back
    starts.delete();
    u_if.report_trig   = 1'b1;
    u_if.report_pred   = 1'b1;
    u_if.report_hidden = 4'hB;
    tick();
    u_if.report_trig = 1'b0;
    sb.push_back(8'h48); sb.push_back(8'h42); sb.push_back(8'h0A);
    check("t2_level_after_report", fifo_level, 4'd3);
    tick();
    c1 = cyc;
    wait_idle(700, c1, t);
    check("t2_total_cycles", t, 3 * FRAME);
    check("t2_frame_count", starts.size(), 3);
    if (starts.size() == 3) begin
      check("t2_gap_1_2", starts[1] - starts[0], FRAME);
      check("t2_gap_2_3", starts[2] - starts[1], FRAME);
    end

    // Report and raw byte in the same cycle: report wins, raw byte goes fourth
    u_if.report_trig   = 1'b1;
    u_if.report_pred   = 1'b0;
    u_if.report_hidden = 4'h3;
    u_if.tx_valid      = 1'b1;
    u_if.tx_data       = 8'h55;
    @(negedge clk);
    check("t3_tx_ready_during_report", u_if.tx_ready, 1'b0);
    tick();
    u_if.report_trig = 1'b0;
    sb.push_back(8'h57); sb.push_back(8'h33); sb.push_back(8'h0A);
    check("t3_level_report_only", fifo_level, 4'd3);
    @(negedge clk);
    check("t3_tx_ready_after", u_if.tx_ready, 1'b1);
    tick();
    u_if.tx_valid = 1'b0;
    sb.push_back(8'h55);
    c1 = cyc;
    check("t3_level_pop_and_push", fifo_level, 4'd3);
    wait_idle(1000, c1, t);
    check("t3_total_cycles", t, 4 * FRAME);

    // Overflow: 6 queued, report dropped; then fill to full
    for (int i = 0; i < 7; i++) push(fill[i]);
    check("t4_level_six", fifo_level, 4'd6);
    u_if.report_trig = 1'b1;
    u_if.report_pred = 1'b1;
    u_if.report_hidden = 4'hF;
    tick();
    u_if.report_trig = 1'b0;
    check("t4_overflow_set", overflow, 1'b1);
    check("t4_level_unchanged", fifo_level, 4'd6);
    push(fill[7]);
    push(fill[8]);
    check("t4_level_full", fifo_level, 4'd8);
    @(negedge clk);
    check("t4_tx_ready_full", u_if.tx_ready, 1'b0);
    tick();
    wait_idle(2000, cyc, t);
    check("t4_drained", busy, 1'b0);
    check("t4_overflow_sticky", overflow, 1'b1);

    // ena dropped for 50 cycles in the middle of data bit 2
    push(8'h96);
    tick();
    c1 = cyc;
    repeat (BD + 2 * BD + 5) tick();
    ena = 1'b0;
    v = uart_tx;
    changed = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (uart_tx !== v) changed = 1'b1;
      if (i == 0) check("t5_tx_ready_disabled", u_if.tx_ready, 1'b0);
    end
    ena = 1'b1;
    check("t5_line_frozen", changed, 1'b0);
    wait_idle(400, c1, t);
    check("t5_stretched_frame", t, FRAME + 50);

    // Reset mid-frame, then a clean frame of 0x07
    push(8'hC3);
    repeat (40) tick();
    rst_n = 1'b0;
    #1;
    check("t6_line_high_async", uart_tx, 1'b1);
    check("t6_level_cleared", fifo_level, 4'd0);
    check("t6_overflow_cleared", overflow, 1'b0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    push(8'h07);
    tick();
    c1 = cyc;
    check("t6_start_after_reset", uart_tx, 1'b0);
    wait_idle(400, c1, t);
    check("t6_frame_cycles", t, FRAME);

    repeat (4) tick();
    check("sb_empty_at_end", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
